// File: rtl/frame_sweeper.sv
// frame_sweeper: on a go pulse, walks every framebuffer pixel in raster order and
// issues one DISPLAY (refresh) or DRAW (clear) instruction per pixel over start/finished.
module frame_sweeper #(
    parameter int         SCREEN_WIDTH   = 160,
    parameter int         SCREEN_HEIGHT  = 120,
    parameter logic [3:0] OPCODE_DRAW    = 4'd0,
    parameter logic [3:0] OPCODE_DISPLAY = 4'd3,
    parameter int         TIMEOUT        = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        go,
    input  logic        mode,
    input  logic [2:0]  clear_colour,
    input  logic        abort,
    input  logic        finished,
    output logic        start,
    output logic [31:0] instruction,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_ACK  = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [7:0]       X_LAST   = 8'(SCREEN_WIDTH - 1);
    localparam logic [6:0]       Y_LAST   = 7'(SCREEN_HEIGHT - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [7:0]       r_x;
    logic [6:0]       r_y;
    logic             r_mode;
    logic [2:0]       r_colour;
    logic             r_abort_pending;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [31:0]      r_instruction;
    logic             r_busy;
    logic             r_done;
    logic             r_error;

    logic             w_start;
    logic             w_accept;
    logic             w_advance;
    logic             w_end;
    logic             w_timed_out;
    logic             w_abort_any;
    logic             w_last_pixel;
    logic             w_wait_limit;
    logic [7:0]       w_next_x;
    logic [6:0]       w_next_y;

    function automatic logic [31:0] pack_instr(input logic m, input logic [2:0] c,
                                               input logic [7:0] x, input logic [6:0] y);
        logic [31:0] v;
        if (m) begin
            v = {9'd0, 1'b1, c, y, x, OPCODE_DRAW};
        end else begin
            v = {9'd0, 1'b0, 3'd0, y, x, OPCODE_DISPLAY};
        end
        return v;
    endfunction

    assign w_abort_any  = r_abort_pending | abort;
    assign w_last_pixel = (r_x == X_LAST) && (r_y == Y_LAST);
    assign w_wait_limit = (r_wait_cnt == CNT_LAST);
    assign w_next_x     = (r_x == X_LAST) ? 8'd0 : r_x + 8'd1;
    assign w_next_y     = (r_x == X_LAST) ? r_y + 7'd1 : r_y;

    // State register; reset forces IDLE so the combinational start drops at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake decode; progress on finished wins over the wait limit.
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_accept     = 1'b0;
        w_advance    = 1'b0;
        w_end        = 1'b0;
        w_timed_out  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (go) begin
                    w_next_state = S_ISSUE;
                    w_accept     = 1'b1;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (w_abort_any) begin
                    w_next_state = S_IDLE;
                    w_end        = 1'b1;
                end else if (finished) begin
                    w_start      = 1'b1;
                    w_next_state = S_WAIT_ACK;
                end else begin
                    w_next_state = S_ISSUE;
                end
            end
            S_WAIT_ACK: begin
                if (!finished) begin
                    w_next_state = S_WAIT_DONE;
                end else if (w_wait_limit) begin
                    w_next_state = S_IDLE;
                    w_end        = 1'b1;
                    w_timed_out  = 1'b1;
                end else begin
                    w_next_state = S_WAIT_ACK;
                end
            end
            S_WAIT_DONE: begin
                if (finished) begin
                    if (w_last_pixel || w_abort_any) begin
                        w_next_state = S_IDLE;
                        w_end        = 1'b1;
                    end else begin
                        w_next_state = S_ISSUE;
                        w_advance    = 1'b1;
                    end
                end else if (w_wait_limit) begin
                    w_next_state = S_IDLE;
                    w_end        = 1'b1;
                    w_timed_out  = 1'b1;
                end else begin
                    w_next_state = S_WAIT_DONE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Sweep context, coordinates, instruction word, wait counter and status flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_x             <= 8'd0;
            r_y             <= 7'd0;
            r_mode          <= 1'b0;
            r_colour        <= 3'd0;
            r_abort_pending <= 1'b0;
            r_wait_cnt      <= '0;
            r_instruction   <= 32'd0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_error         <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mode        <= mode;
                r_colour      <= clear_colour;
                r_x           <= 8'd0;
                r_y           <= 7'd0;
                r_instruction <= pack_instr(mode, clear_colour, 8'd0, 7'd0);
            end else if (w_advance) begin
                r_x           <= w_next_x;
                r_y           <= w_next_y;
                r_instruction <= pack_instr(r_mode, r_colour, w_next_x, w_next_y);
            end

            if (w_next_state != r_state) begin
                r_wait_cnt <= '0;
            end else if ((r_state == S_WAIT_ACK) || (r_state == S_WAIT_DONE)) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end else begin
                r_wait_cnt <= '0;
            end

            if (w_end || w_accept) begin
                r_abort_pending <= 1'b0;
            end else if ((r_state != S_IDLE) && abort) begin
                r_abort_pending <= 1'b1;
            end

            if (w_accept) begin
                r_error <= 1'b0;
            end else if (w_timed_out) begin
                r_error <= 1'b1;
            end

            r_busy <= (w_next_state != S_IDLE);
            r_done <= w_end;
        end
    end

    assign start       = w_start;
    assign instruction = r_instruction;
    assign busy        = r_busy;
    assign done        = r_done;
    assign error       = r_error;

endmodule
